latch_bank_ctrl: RTL

LATCH_BANK_CTRL -- requirements
Module: latch_bank_ctrl

---
 rtl/latch_bank_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/latch_bank_ctrl.sv
// Two-requester round-robin controller driving a bank of level-sensitive latch rows.
// Define LATCH_BANK_CTRL_SET_EN to enable the set operation (op 2'b10) on LAT_SETN.
module latch_bank_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned PULSE = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [1:0]                   REQ_VALID,
  input  logic [3:0]                   REQ_OP,
  input  logic [2*$clog2(ROWS)-1:0]    REQ_ROW,
  input  logic [2*WIDTH-1:0]           REQ_D,
  output logic [1:0]                   REQ_READY,
  output logic [WIDTH-1:0]             LAT_D,
  output logic [ROWS-1:0]              LAT_E,
  output logic [ROWS-1:0]              LAT_RN,
  output logic [ROWS-1:0]              LAT_SETN,
  output logic                         BUSY,
  output logic                         GRANT
);

  localparam int unsigned RowW = $clog2(ROWS);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpClear = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;

  typedef enum logic [1:0] {StIdle, StSetup, StActive, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        op_q;
  logic [RowW-1:0]   row_q;
  logic [WIDTH-1:0]  lat_d_q;
  logic              grant_q;
  logic [ROWS-1:0]   lat_e_q, lat_e_d;
  logic [ROWS-1:0]   lat_rn_q, lat_rn_d;
  logic [ROWS-1:0]   row_oh;

  logic              sel;
  logic [1:0]        ready;
  logic              accept;
  logic [1:0]        sel_op;
  logic [RowW-1:0]   sel_row;
  logic [WIDTH-1:0]  sel_d;

  // Ready is gated by RST so it drops immediately with the asynchronous reset.
  always_comb begin
    ready = 2'b00;
    sel   = grant_q;
    if (state_q == StIdle && !RST) begin
      unique case (REQ_VALID)
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        2'b11:   sel = ~grant_q;
        default: sel = grant_q;
      endcase
      if (REQ_VALID != 2'b00) begin
        ready[sel] = 1'b1;
      end
    end
  end

  assign accept  = |(REQ_VALID & ready);
  assign sel_op  = sel ? REQ_OP[3:2] : REQ_OP[1:0];
  assign sel_row = sel ? REQ_ROW[2*RowW-1:RowW] : REQ_ROW[RowW-1:0];
  assign sel_d   = sel ? REQ_D[2*WIDTH-1:WIDTH] : REQ_D[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StActive;
        cnt_d   = 4'd0;
      end
      StActive: begin
        if (cnt_q == 4'(PULSE - 1)) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    row_oh        = '0;
    row_oh[row_q] = 1'b1;
  end

  // Strobes are computed from the next state and registered, so they are glitch-free
  // and line up exactly with the ACTIVE cycles.
  always_comb begin
    lat_e_d  = '0;
    lat_rn_d = '1;
    if (state_d == StActive) begin
      unique case (op_q)
        OpWrite: lat_e_d  = row_oh;
        OpClear: lat_rn_d = ~row_oh;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      op_q     <= OpWrite;
      row_q    <= '0;
      lat_d_q  <= '0;
      grant_q  <= 1'b1;
      lat_e_q  <= '0;
      lat_rn_q <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_e_q  <= lat_e_d;
      lat_rn_q <= lat_rn_d;
      if (accept) begin
        op_q    <= sel_op;
        row_q   <= sel_row;
        lat_d_q <= sel_d;
        grant_q <= sel;
      end
    end
  end

`ifdef LATCH_BANK_CTRL_SET_EN
  logic [ROWS-1:0] lat_setn_q, lat_setn_d;

  always_comb begin
    lat_setn_d = '1;
    if (state_d == StActive && op_q == OpSet) begin
      lat_setn_d = ~row_oh;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_setn_q <= '1;
    end else begin
      lat_setn_q <= lat_setn_d;
    end
  end

  assign LAT_SETN = lat_setn_q;
`else
  // Without set support op 2'b10 runs as a reserved op and LAT_SETN never moves.
  assign LAT_SETN = '1;
`endif

  assign REQ_READY = ready;
  assign LAT_D     = lat_d_q;
  assign LAT_E     = lat_e_q;
  assign LAT_RN    = lat_rn_q;
  assign BUSY      = (state_q != StIdle);
  assign GRANT     = grant_q;

`ifndef SYNTHESIS
  ready_onehot_a: assert property (@(posedge CLK) disable iff (RST) $onehot0(REQ_READY));
  ready_idle_a: assert property (@(posedge CLK) disable iff (RST)
    (REQ_READY != 2'b00) |-> (state_q == StIdle));
  strobe_active_a: assert property (@(posedge CLK) disable iff (RST)
    (state_q != StActive) |-> (LAT_E == '0 && LAT_RN == '1 && LAT_SETN == '1));
`endif

endmodule
